// File: rtl/wr_fifo_arbiter_pkg.sv
// Shared DDR2 write-path definitions: default widths and arbiter state encodings.
package wr_fifo_arbiter_pkg;

  localparam int unsigned DDR2_ADDR_W = 31;
  localparam int unsigned DDR2_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CMD   = 2'b01,
    ST_DATA2 = 2'b10
  } wr_state_e;

endpackage

// File: rtl/wr_fifo_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; the pointer names the port that wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  logic rr_q;
  logic rr_d;

  // Grant the lone requester, or the pointed-to port on a tie; move pointer past the winner.
  always_comb begin
    grant_c = 2'b00;
    rr_d    = rr_q;
    unique case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = rr_q ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
    if (advance && (grant_c != 2'b00)) begin
      rr_d = grant_c[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/wr_fifo_arbiter.sv
// Arbitrates two 2-beat write bursts into the DDR2 address and write-data FIFOs.
module wr_fifo_arbiter
  import wr_fifo_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DDR2_ADDR_W,
  parameter int unsigned DATA_W = DDR2_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_data0,
  input  logic [DATA_W-1:0]     p0_data1,
  input  logic [DATA_W/8-1:0]   p0_mask0,
  input  logic [DATA_W/8-1:0]   p0_mask1,
  output logic                  p0_ready,
  input  logic                  p1_valid,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_data0,
  input  logic [DATA_W-1:0]     p1_data1,
  input  logic [DATA_W/8-1:0]   p1_mask0,
  input  logic [DATA_W/8-1:0]   p1_mask1,
  output logic                  p1_ready,
  input  logic                  af_full,
  input  logic                  wdf_full,
  output logic [ADDR_W-1:0]     af_addr_din,
  output logic                  af_wr_en,
  output logic [DATA_W-1:0]     wdf_din,
  output logic [DATA_W/8-1:0]   wdf_mask_din,
  output logic                  wdf_wr_en,
  output logic                  busy
);

  localparam int unsigned MASK_W = DATA_W / 8;

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [MASK_W-1:0]   mask0_q, mask0_d;
  logic [MASK_W-1:0]   mask1_q, mask1_d;
  logic [1:0]          grant_c;
  logic                accept_c;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_valid, p0_valid}),
    .advance (accept_c),
    .grant_c (grant_c)
  );

  // A burst is taken from IDLE, or from DATA2 once its last beat drains; never under reset.
  assign accept_c = !rst && (p0_valid || p1_valid) &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DATA2) && !wdf_full));

  // Next state, burst capture and FIFO-side decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    mask0_d      = mask0_q;
    mask1_d      = mask1_q;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    af_wr_en     = 1'b0;
    wdf_wr_en    = 1'b0;
    af_addr_din  = addr_q;
    wdf_din      = data0_q;
    wdf_mask_din = '1;
    busy         = (state_q != ST_IDLE);

    if (accept_c) begin
      p0_ready = grant_c[0];
      p1_ready = grant_c[1];
      if (grant_c[1]) begin
        addr_d  = p1_addr;
        data0_d = p1_data0;
        data1_d = p1_data1;
        mask0_d = p1_mask0;
        mask1_d = p1_mask1;
      end else begin
        addr_d  = p0_addr;
        data0_d = p0_data0;
        data1_d = p0_data1;
        mask0_d = p0_mask0;
        mask1_d = p0_mask1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_CMD;
      end
      ST_CMD: begin
        af_wr_en     = 1'b1;
        wdf_wr_en    = 1'b1;
        wdf_din      = data0_q;
        wdf_mask_din = mask0_q;
        if (!af_full && !wdf_full) state_d = ST_DATA2;
      end
      ST_DATA2: begin
        wdf_wr_en    = 1'b1;
        wdf_din      = data1_q;
        wdf_mask_din = mask1_q;
        if (!wdf_full) state_d = accept_c ? ST_CMD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and burst buffer registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
      mask0_q <= '0;
      mask1_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      mask0_q <= mask0_d;
      mask1_q <= mask1_d;
    end
  end

endmodule
